time_synch_gen: RTL and testbench



---
 rtl/time_synch_gen.sv | 259 +++++++++++++++++++++++++
 tb/tb_time_synch_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_synch_gen.sv
`default_nettype none
// ============================================================================
// Module   : time_synch_gen
// Purpose  : 802.16 OFDM timing-synchroniser back end. It detects the preamble
//            with a confirmed |P| > coeff*R test, then searches a window for
//            the |P| peak, reports P at the peak and signals syn_done.
//            Optional search watchdog is compiled in with TSYN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module time_synch_gen #(
    parameter int PW      = 16,
    parameter int RW      = 16,
    parameter int CW      = 17,
    parameter int HIT_N   = 8,
    parameter int WIN     = 64,
    parameter int SYN_DLY = 54,
    parameter int TMO     = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 syn_run,
    input  logic                 metric_val,
    input  logic signed [PW-1:0] p_re,
    input  logic signed [PW-1:0] p_im,
    input  logic [RW-1:0]        r_metric,
    input  logic [CW-1:0]        thres_coeff,
    output logic [2*PW-1:0]      fre_o,
    output logic                 fre_val,
    output logic [9:0]           peak_idx,
    output logic                 syn_done,
    output logic                 syn_fail,
    output logic [2:0]           state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_PEAK   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int MW  = (PW + 1 > RW + 2) ? PW + 1 : RW + 2;
    localparam int PRW = RW + CW;

    localparam logic [7:0] HIT_N_C   = 8'(HIT_N);
    localparam logic [9:0] WIN_LAST  = 10'(WIN - 1);
    localparam logic [9:0] SYN_DLY_C = 10'(SYN_DLY);

    // |x| with the most-negative code saturated so it still fits in PW-1 bits
    function automatic logic [PW-2:0] f_abs(input logic signed [PW-1:0] x);
        if (x == {1'b1, {(PW-1){1'b0}}})
            return {(PW-1){1'b1}};
        else if (x < 0)
            return (PW-1)'(-x);
        else
            return (PW-1)'(x);
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: magnitude estimate, threshold and hit decision
    // ------------------------------------------------------------------
    logic [PW-2:0]        w_abs_re, w_abs_im, w_max, w_min;
    logic [PW:0]          w_mag;
    logic [PRW-1:0]       w_prod;
    logic [RW+1:0]        w_thr;
    logic                 w_hit;

    logic                 v1_q;
    logic [PW:0]          mag1_q;
    logic                 hit1_q;
    logic signed [PW-1:0] re1_q, im1_q;

    always_comb begin
        w_abs_re = f_abs(p_re);
        w_abs_im = f_abs(p_im);
        if (w_abs_re >= w_abs_im) begin
            w_max = w_abs_re;
            w_min = w_abs_im;
        end else begin
            w_max = w_abs_im;
            w_min = w_abs_re;
        end
        w_mag  = (PW+1)'(w_max) + (PW+1)'(w_min >> 1);
        w_prod = PRW'(r_metric) * PRW'(thres_coeff);
        w_thr  = (RW+2)'(w_prod >> (CW - 2));
        w_hit  = MW'(w_mag) > MW'(w_thr);
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [2:0]      state_q, state_d;
    logic [7:0]      hit_cnt_q, hit_cnt_d;
    logic [9:0]      win_cnt_q, win_cnt_d;
    logic [9:0]      dly_cnt_q, dly_cnt_d;
    logic [PW:0]     peak_mag_q, peak_mag_d;
    logic [2*PW-1:0] fre_q, fre_d;
    logic [9:0]      peak_idx_q, peak_idx_d;
    logic            fre_val_q, fre_val_d;

`ifdef TSYN_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_C = TW'(TMO);
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0]   w_tmo_inc;
    logic            syn_fail_q, syn_fail_d;
`endif

    logic [7:0] w_hit_inc;
    logic [9:0] w_dly_inc;
    logic       w_confirm;
    logic       w_wait_done;
    logic [9:0] w_idx;

    always_comb begin
        w_hit_inc   = (hit_cnt_q >= HIT_N_C) ? HIT_N_C : hit_cnt_q + 8'd1;
        w_dly_inc   = (dly_cnt_q == 10'h3FF) ? dly_cnt_q : dly_cnt_q + 10'd1;
        w_confirm   = hit1_q && (w_hit_inc == HIT_N_C);
        // An early peak may leave dly_cnt already past SYN_DLY at window end
        w_wait_done = (dly_cnt_q >= SYN_DLY_C) || (v1_q && (w_dly_inc >= SYN_DLY_C));
        w_idx       = (state_q == S_PEAK) ? win_cnt_q : 10'd0;
    end

    // State register (all sequential state)
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            mag1_q     <= '0;
            hit1_q     <= 1'b0;
            re1_q      <= '0;
            im1_q      <= '0;
            state_q    <= S_IDLE;
            hit_cnt_q  <= '0;
            win_cnt_q  <= '0;
            dly_cnt_q  <= '0;
            peak_mag_q <= '0;
            fre_q      <= '0;
            peak_idx_q <= '0;
            fre_val_q  <= 1'b0;
`ifdef TSYN_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            syn_fail_q <= 1'b0;
`endif
        end else begin
            v1_q <= metric_val;
            if (metric_val) begin
                mag1_q <= w_mag;
                hit1_q <= w_hit;
                re1_q  <= p_re;
                im1_q  <= p_im;
            end
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            win_cnt_q  <= win_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            peak_mag_q <= peak_mag_d;
            fre_q      <= fre_d;
            peak_idx_q <= peak_idx_d;
            fre_val_q  <= fre_val_d;
`ifdef TSYN_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            syn_fail_q <= syn_fail_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!syn_run) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_SEARCH;
                S_SEARCH: if (v1_q && w_confirm) state_d = S_PEAK;
                S_PEAK:   if (v1_q && (win_cnt_q == WIN_LAST)) state_d = S_WAIT;
                S_WAIT:   if (w_wait_done) state_d = S_DONE;
                S_DONE:   state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Counter and peak-capture datapath
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        win_cnt_d  = win_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        peak_mag_d = peak_mag_q;
        fre_d      = fre_q;
        peak_idx_d = peak_idx_q;
        fre_val_d  = 1'b0;
`ifdef TSYN_TIMEOUT_EN
        w_tmo_inc  = tmo_cnt_q + TW'(1);
        tmo_cnt_d  = '0;
        syn_fail_d = 1'b0;
`endif
        if (!syn_run || (state_q == S_IDLE)) begin
            hit_cnt_d = '0;
            win_cnt_d = '0;
            dly_cnt_d = '0;
        end else if (v1_q) begin
            case (state_q)
                S_SEARCH: begin
                    hit_cnt_d = hit1_q ? w_hit_inc : 8'd0;
`ifdef TSYN_TIMEOUT_EN
                    tmo_cnt_d = w_tmo_inc;
                    if (!w_confirm && (w_tmo_inc == TMO_C)) begin
                        syn_fail_d = 1'b1;
                        hit_cnt_d  = '0;
                        tmo_cnt_d  = '0;
                    end
`endif
                    // The confirming sample is window index 0
                    if (w_confirm) begin
                        peak_mag_d = mag1_q;
                        fre_d      = {im1_q, re1_q};
                        peak_idx_d = w_idx;
                        dly_cnt_d  = '0;
                        win_cnt_d  = 10'd1;
`ifdef TSYN_TIMEOUT_EN
                        tmo_cnt_d  = '0;
`endif
                    end
                end
                S_PEAK: begin
                    // Strict compare: ties keep the earlier sample
                    if ((win_cnt_q == 10'd0) || (mag1_q > peak_mag_q)) begin
                        peak_mag_d = mag1_q;
                        fre_d      = {im1_q, re1_q};
                        peak_idx_d = w_idx;
                        dly_cnt_d  = '0;
                    end else begin
                        dly_cnt_d  = w_dly_inc;
                    end
                    win_cnt_d = win_cnt_q + 10'd1;
                    if (win_cnt_q == WIN_LAST) fre_val_d = 1'b1;
                end
                S_WAIT:  dly_cnt_d = w_dly_inc;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        fre_o    = fre_q;
        fre_val  = fre_val_q;
        peak_idx = peak_idx_q;
        syn_done = (state_q == S_DONE);
        state_o  = state_q;
`ifdef TSYN_TIMEOUT_EN
        syn_fail = syn_fail_q;
`else
        syn_fail = (TMO < 0);
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_time_synch_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_synch_gen
// Purpose  : Directed self-checking bench for time_synch_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_synch_gen;

    localparam int WIN = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               syn_run = 1'b0;
    logic               metric_val = 1'b0;
    logic signed [15:0] p_re = '0;
    logic signed [15:0] p_im = '0;
    logic [15:0]        r_metric = 16'd1000;
    logic [16:0]        thres_coeff = 17'h04000;
    logic [31:0]        fre_o;
    logic               fre_val;
    logic [9:0]         peak_idx;
    logic               syn_done;
    logic               syn_fail;
    logic [2:0]         state_o;

    time_synch_gen #(
        .PW(16), .RW(16), .CW(17), .HIT_N(8), .WIN(WIN), .SYN_DLY(54), .TMO(100)
    ) u_dut (
        .clk(clk), .rst(rst), .syn_run(syn_run), .metric_val(metric_val),
        .p_re(p_re), .p_im(p_im), .r_metric(r_metric), .thres_coeff(thres_coeff),
        .fre_o(fre_o), .fre_val(fre_val), .peak_idx(peak_idx),
        .syn_done(syn_done), .syn_fail(syn_fail), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Count of samples decided by the DUT so far (its v1 stage)
    logic mv1 = 1'b0;
    int   pcnt = 0;
    always @(posedge clk) begin
        mv1 <= rst ? 1'b0 : metric_val;
        if (mv1) pcnt <= pcnt + 1;
    end

    // Event recorder, tagged with the decided-sample count
    int   peak_rise_at = 0, done_rise_at = 0, done_rises = 0;
    int   fv_count = 0, fv_at = 0, sf_count = 0, sf_at = 0, sf_prev = 0;
    int   off_search = 0;
    logic watch = 1'b0, prev_peak = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        prev_peak <= (state_o == 3'd2);
        prev_done <= syn_done;
        if ((state_o == 3'd2) && !prev_peak) peak_rise_at <= pcnt;
        if (syn_done && !prev_done) begin
            done_rise_at <= pcnt;
            done_rises   <= done_rises + 1;
        end
        if (fre_val) begin
            fv_count <= fv_count + 1;
            fv_at    <= pcnt;
        end
        if (syn_fail) begin
            sf_count <= sf_count + 1;
            sf_prev  <= sf_at;
            sf_at    <= pcnt;
        end
        if (watch && (state_o != 3'd1)) off_search <= off_search + 1;
    end

    int n_checks = 0, n_errors = 0;
    int base = 0, fv0 = 0, dr0 = 0, sf0 = 0, off0 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic samp(input int re, input int im, input int gap);
        metric_val = 1'b1;
        p_re = 16'(re);
        p_im = 16'(im);
        idle(1);
        metric_val = 1'b0;
        idle(gap);
    endtask

    task automatic rearm();
        syn_run = 1'b0;
        idle(1);
        syn_run = 1'b1;
        idle(2);
    endtask

    // 7 hits (optionally preceded by 7 hits + 1 miss), then WIN window samples
    // of (600,0) with overrides at offsets i1/i2, then post extra samples.
    task automatic window(input int lead, input int gap,
                          input int i1, input int re1, input int im1,
                          input int i2, input int re2, input int im2,
                          input int post, input int abort_at);
        base = pcnt;
        fv0  = fv_count;
        dr0  = done_rises;
        if (lead != 0) begin
            for (int k = 0; k < 7; k++) samp(600, 0, gap);
            samp(400, 0, gap);
        end
        for (int k = 0; k < 7; k++) samp(600, 0, gap);
        for (int o = 0; o < WIN; o++) begin
            if (o == i1)      samp(re1, im1, gap);
            else if (o == i2) samp(re2, im2, gap);
            else              samp(600, 0, gap);
            if (o == abort_at) syn_run = 1'b0;
        end
        for (int k = 0; k < post; k++) samp(600, 0, gap);
        idle(4);
    endtask

    initial begin
        idle(3);
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_fre_o", 64'(fre_o), 64'd0);
        check("rst_idx", 64'(peak_idx), 64'd0);
        check("rst_flags", 64'({fre_val, syn_done, syn_fail}), 64'd0);
        rst = 1'b0;
        syn_run = 1'b1;
        idle(2);
        check("t1_search", 64'(state_o), 64'd1);

        // 1: detection, peak at offset 5 (mag 1050 vs thr 500)
        window(0, 0, 5, 900, 300, -1, 0, 0, 0, -1);
        check("t1_peak_at", 64'(peak_rise_at - base), 64'd8);
        check("t1_fv_cnt", 64'(fv_count - fv0), 64'd1);
        check("t1_fv_at", 64'(fv_at - base), 64'd71);
        check("t1_fre_o", 64'(fre_o), 64'h012C0384);
        check("t1_idx", 64'(peak_idx), 64'd5);
        check("t1_done", 64'(syn_done), 64'd1);
        check("t1_done_at", 64'(done_rise_at - base), 64'd71);
        check("t1_state", 64'(state_o), 64'd4);
        syn_run = 1'b0;
        idle(1);
        check("t1_abort_state", 64'({state_o, syn_done}), 64'd0);
        check("t1_fre_kept", 64'({fre_o, peak_idx}), {22'd0, 32'h012C0384, 10'd5});
        syn_run = 1'b1;
        idle(2);

        // 2: hit-run restart, all-equal window keeps index 0
        window(1, 0, -1, 0, 0, -1, 0, 0, 0, -1);
        check("t2_peak_at", 64'(peak_rise_at - base), 64'd16);
        check("t2_fv_at", 64'(fv_at - base), 64'd79);
        check("t2_idx", 64'(peak_idx), 64'd0);
        check("t2_fre_o", 64'(fre_o), 64'h00000258);
        rearm();

        // 3: ties and signs
        window(0, 0, 3, 1000, 0, 9, -800, -400, 0, -1);
        check("t3_tie_idx", 64'(peak_idx), 64'd3);
        check("t3_tie_fre", 64'(fre_o), 64'h000003E8);
        rearm();
        window(0, 0, 12, 32767, 0, 15, -32768, 0, 0, -1);
        check("t3_sat_idx", 64'(peak_idx), 64'd12);
        check("t3_sat_fre", 64'(fre_o), 64'h00007FFF);
        rearm();
        window(0, 0, 7, -32768, -32768, -1, 0, 0, 0, -1);
        check("t3_neg_idx", 64'(peak_idx), 64'd7);
        check("t3_neg_fre", 64'(fre_o), 64'h80008000);
        rearm();

        // Late peak: WAIT counts to 54 samples after the peak, gapped and not
        window(0, 0, 60, 900, 300, -1, 0, 0, 60, -1);
        check("tl_idx", 64'(peak_idx), 64'd60);
        check("tl_fv_at", 64'(fv_at - base), 64'd71);
        check("tl_done_at", 64'(done_rise_at - base), 64'd122);
        rearm();
        window(0, 2, 60, 900, 300, -1, 0, 0, 60, -1);
        check("t4_fv_at", 64'(fv_at - base), 64'd71);
        check("t4_done_at", 64'(done_rise_at - base), 64'd122);
        check("t4_done", 64'(syn_done), 64'd1);
        rearm();

        // 4: abort at offset 20 with gapped strobes
        window(0, 2, 10, 800, 700, -1, 0, 0, 0, 20);
        check("t4_ab_fv", 64'(fv_count - fv0), 64'd0);
        check("t4_ab_done", 64'(done_rises - dr0), 64'd0);
        check("t4_ab_state", 64'({state_o, syn_done}), 64'd0);
        check("t4_ab_kept", 64'({fre_o, peak_idx}), {22'd0, 32'h02BC0320, 10'd10});

        // 5: watchdog with no hits
        syn_run = 1'b1;
        idle(2);
        base  = pcnt;
        sf0   = sf_count;
        off0  = off_search;
        watch = 1'b1;
        for (int k = 0; k < 210; k++) samp(400, 0, 0);
        idle(3);
        watch = 1'b0;
`ifdef TSYN_TIMEOUT_EN
        check("t5_sf_cnt", 64'(sf_count - sf0), 64'd2);
        check("t5_sf_1st", 64'(sf_prev - base), 64'd100);
        check("t5_sf_2nd", 64'(sf_at - base), 64'd200);
`else
        check("t5_sf_cnt", 64'(sf_count - sf0), 64'd0);
`endif
        check("t5_in_search", 64'(off_search - off0), 64'd0);
        rearm();

        // 6: reset during WAIT
        window(0, 0, 60, 900, 300, -1, 0, 0, 20, -1);
        check("t6_wait", 64'(state_o), 64'd3);
        rst = 1'b1;
        idle(1);
        check("t6_rst_state", 64'(state_o), 64'd0);
        check("t6_rst_out", 64'({fre_o, peak_idx, fre_val, syn_done, syn_fail}), 64'd0);
        rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
